// File: rtl/divclk_monitor.sv
// Divided-clock checker: measures period/high time of clk_in in clk cycles, flags period errors and stalls.
// Optional high-time symmetry check (duty_err) is enabled by defining DIVMON_DUTY_CHECK_EN.
module divclk_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             period_err,
  output logic             stall
`ifdef DIVMON_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_W      = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_W      = (CNT_W + 1)'(TOL);

  state_t           state, state_next;
  logic             r0, r1, rise;
  logic [CNT_W-1:0] cnt, hcnt, cnt_inc, hcnt_inc;
  logic [CNT_W:0]   period_full, exp_diff;
  logic             period_bad, meas_fire;

  assign rise = r0 & ~r1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == IDLE && rise) state_next = MEASURE;
  end

  // cnt_inc doubles as the saturated period so a pegged counter reports 2^CNT_W-1, not 0.
  always_comb begin
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    hcnt_inc    = (hcnt == CNT_MAX) ? hcnt : hcnt + 1'b1;
    period_full = {1'b0, cnt} + 1'b1;
    exp_diff    = (period_full >= EXP_W) ? period_full - EXP_W : EXP_W - period_full;
    period_bad  = exp_diff > TOL_W;
    meas_fire   = rise && (state == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0         <= 1'b0;
      r1         <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      stall      <= 1'b0;
    end else begin
      r0         <= clk_in;
      r1         <= r0;
      meas_valid <= meas_fire;
      if (rise) begin
        cnt   <= '0;
        hcnt  <= CNT_W'(1);
        stall <= 1'b0;
      end else begin
        cnt <= cnt_inc;
        if (r0 && state == MEASURE) hcnt <= hcnt_inc;
        // Fires on the edge where cnt becomes TIMEOUT; a coincident rise takes priority above.
        if (cnt == TIMEOUT_M1) stall <= 1'b1;
      end
      if (meas_fire) begin
        period_out <= cnt_inc;
        high_out   <= hcnt;
        if (period_bad) period_err <= 1'b1;
      end
    end
  end

`ifdef DIVMON_DUTY_CHECK_EN
  logic [CNT_W+1:0] twice_h, per_x, duty_diff;
  logic             duty_bad;

  always_comb begin
    twice_h   = {1'b0, hcnt, 1'b0};
    per_x     = {1'b0, period_full};
    duty_diff = (twice_h >= per_x) ? twice_h - per_x : per_x - twice_h;
    duty_bad  = duty_diff > (CNT_W + 2)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                      duty_err <= 1'b0;
    else if (meas_fire && duty_bad) duty_err <= 1'b1;
  end
`endif

endmodule
